// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, FSM encoding
// and the access-type legality check.
package dmem_arb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Stores have no unsigned variants; loads accept all five size codes.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Grant is combinational; the last winner is
// remembered only when the caller reports that the grant was taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_id = 1'b0;
    grant    = 2'b00;
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end else if (req[1]) begin
      grant_id = 1'b1;
    end
    if (req != 2'b00) begin
      grant = grant_id ? 2'b10 : 2'b01;
    end
  end

  // Resetting to 1 makes port 0 the first winner under contention.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the data memory: one request
// at a time, a single-cycle memory access, then a one-cycle registered response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [31:0]       p0_req_wdata,
  input  logic [2:0]        p0_req_funct3,
  output logic              p0_resp_valid,
  output logic [31:0]       p0_resp_rdata,
  output logic              p0_resp_err,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [31:0]       p1_req_wdata,
  input  logic [2:0]        p1_req_funct3,
  output logic              p1_resp_valid,
  output logic [31:0]       p1_resp_rdata,
  output logic              p1_resp_err,

  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_read_data
);

  localparam logic [ADDR_W-1:0] MEM_WORDS_A = ADDR_W'(MEM_WORDS);

  state_t state_q, state_d;

  logic [1:0]        grant;
  logic              grant_id;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_funct3;
  logic              sel_legal;

  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_funct3;
  logic              lat_port;
  logic              err_q;
  logic [31:0]       rdata_q;

  // Requests are only visible to the picker in IDLE and outside reset, so
  // ready is never raised while a transaction is in flight.
  logic [1:0] arb_req;
  assign arb_req = {p1_req_valid, p0_req_valid} & {2{(state_q == IDLE) && !reset}};
  assign accept  = |grant;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req      (arb_req),
    .update   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];

  assign sel_we     = grant_id ? p1_req_we     : p0_req_we;
  assign sel_addr   = grant_id ? p1_req_addr   : p0_req_addr;
  assign sel_wdata  = grant_id ? p1_req_wdata  : p0_req_wdata;
  assign sel_funct3 = grant_id ? p1_req_funct3 : p0_req_funct3;
  assign sel_legal  = is_legal(sel_we, sel_funct3) && (sel_addr < MEM_WORDS_A);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Illegal requests skip ACCESS so they can never touch memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = sel_legal ? ACCESS : RESP;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_funct3 <= '0;
      lat_port   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else if (state_q == IDLE && accept) begin
      lat_we     <= sel_we;
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
      lat_funct3 <= sel_funct3;
      lat_port   <= grant_id;
      err_q      <= !sel_legal;
      rdata_q    <= '0;
    end else if (state_q == ACCESS) begin
      rdata_q <= lat_we ? 32'd0 : mem_read_data;
    end
  end

  // Memory and response buses are decoded from state so an asynchronous reset
  // drops them in the same instant.
  always_comb begin
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_funct3     = '0;
    p0_resp_valid  = 1'b0;
    p0_resp_rdata  = '0;
    p0_resp_err    = 1'b0;
    p1_resp_valid  = 1'b0;
    p1_resp_rdata  = '0;
    p1_resp_err    = 1'b0;
    if (state_q == ACCESS) begin
      mem_MemRead    = !lat_we;
      mem_MemWrite   = lat_we;
      mem_address    = lat_addr;
      mem_write_data = lat_wdata;
      mem_funct3     = lat_funct3;
    end else if (state_q == RESP) begin
      if (lat_port) begin
        p1_resp_valid = 1'b1;
        p1_resp_rdata = rdata_q;
        p1_resp_err   = err_q;
      end else begin
        p0_resp_valid = 1'b1;
        p0_resp_rdata = rdata_q;
        p0_resp_err   = err_q;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word-addressed memory that
// applies funct3 size and sign rules on the low bytes of each word.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic [2:0]  p0_req_funct3;
  logic        p0_resp_valid, p0_resp_err;
  logic [31:0] p0_resp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic [2:0]  p1_req_funct3;
  logic        p1_resp_valid, p1_resp_err;
  logic [31:0] p1_resp_rdata;
  logic        mem_MemRead, mem_MemWrite;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [2:0]  mem_funct3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req_valid   (p0_req_valid),
    .p0_req_ready   (p0_req_ready),
    .p0_req_we      (p0_req_we),
    .p0_req_addr    (p0_req_addr),
    .p0_req_wdata   (p0_req_wdata),
    .p0_req_funct3  (p0_req_funct3),
    .p0_resp_valid  (p0_resp_valid),
    .p0_resp_rdata  (p0_resp_rdata),
    .p0_resp_err    (p0_resp_err),
    .p1_req_valid   (p1_req_valid),
    .p1_req_ready   (p1_req_ready),
    .p1_req_we      (p1_req_we),
    .p1_req_addr    (p1_req_addr),
    .p1_req_wdata   (p1_req_wdata),
    .p1_req_funct3  (p1_req_funct3),
    .p1_resp_valid  (p1_resp_valid),
    .p1_resp_rdata  (p1_resp_rdata),
    .p1_resp_err    (p1_resp_err),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_funct3     (mem_funct3),
    .mem_read_data  (mem_read_data)
  );

  // Behavioural data memory: byte/half accesses use the low lanes of the word.
  logic [31:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

  always @(posedge clk) begin
    if (mem_MemWrite) begin
      case (mem_funct3)
        3'b000:  mem[mem_address[9:0]][7:0]  <= mem_write_data[7:0];
        3'b001:  mem[mem_address[9:0]][15:0] <= mem_write_data[15:0];
        default: mem[mem_address[9:0]]       <= mem_write_data;
      endcase
    end
  end

  always_comb begin
    logic [31:0] w;
    w = mem[mem_address[9:0]];
    case (mem_funct3)
      3'b000:  mem_read_data = {{24{w[7]}}, w[7:0]};
      3'b001:  mem_read_data = {{16{w[15]}}, w[15:0]};
      3'b100:  mem_read_data = {24'd0, w[7:0]};
      3'b101:  mem_read_data = {16'd0, w[15:0]};
      default: mem_read_data = w;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input int port, input logic v, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3);
    if (port == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata; p0_req_funct3 = f3;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata; p1_req_funct3 = f3;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction
  function automatic logic rv(input int p);
    return (p == 0) ? p0_resp_valid : p1_resp_valid;
  endfunction
  function automatic logic [31:0] rd(input int p);
    return (p == 0) ? p0_resp_rdata : p1_resp_rdata;
  endfunction
  function automatic logic re(input int p);
    return (p == 0) ? p0_resp_err : p1_resp_err;
  endfunction

  typedef struct {
    string       name;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [17];

  // One transaction with the bus idle: ready now, access next cycle, response
  // the cycle after (or immediately after accept for errors).
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.addr, v.wdata, v.f3);
    #1;
    check({v.name, " ready"}, 32'(rdy(v.port)), 32'd1);
    check({v.name, " other ready"}, 32'(rdy(1 - v.port)), 32'd0);
    @(posedge clk);
    #1 drive(v.port, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    if (v.exp_err) begin
      check({v.name, " no mem op"}, {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    end else begin
      check({v.name, " mem rw"}, {30'd0, mem_MemRead, mem_MemWrite}, {30'd0, !v.we, v.we});
      check({v.name, " mem addr"}, mem_address, v.addr);
      check({v.name, " early resp"}, 32'(rv(v.port)), 32'd0);
      @(negedge clk);
    end
    check({v.name, " resp_valid"}, 32'(rv(v.port)), 32'd1);
    check({v.name, " resp_err"}, 32'(re(v.port)), 32'(v.exp_err));
    check({v.name, " resp_rdata"}, rd(v.port), v.exp_rdata);
    check({v.name, " other resp"}, 32'(rv(1 - v.port)), 32'd0);
  endtask

  initial begin
    int last_cycle;
    int cyc;
    bit got;

    vecs[0]  = '{"sw5",        0, 1'b1, 32'd5,    32'hDEADBEEF, 3'b010, 1'b0, 32'h0};
    vecs[1]  = '{"lw5",        0, 1'b0, 32'd5,    32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{"sw7",        0, 1'b1, 32'd7,    32'h000080FF, 3'b010, 1'b0, 32'h0};
    vecs[3]  = '{"lb7",        1, 1'b0, 32'd7,    32'h0,        3'b000, 1'b0, 32'hFFFFFFFF};
    vecs[4]  = '{"lbu7",       1, 1'b0, 32'd7,    32'h0,        3'b100, 1'b0, 32'h000000FF};
    vecs[5]  = '{"lh7",        1, 1'b0, 32'd7,    32'h0,        3'b001, 1'b0, 32'hFFFF80FF};
    vecs[6]  = '{"lhu7",       1, 1'b0, 32'd7,    32'h0,        3'b101, 1'b0, 32'h000080FF};
    vecs[7]  = '{"ld_f3_011",  0, 1'b0, 32'd5,    32'h0,        3'b011, 1'b1, 32'h0};
    vecs[8]  = '{"sw1024",     0, 1'b1, 32'd1024, 32'h11111111, 3'b010, 1'b1, 32'h0};
    vecs[9]  = '{"lw5_after",  1, 1'b0, 32'd5,    32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{"sw1023",     1, 1'b1, 32'd1023, 32'h12345678, 3'b010, 1'b0, 32'h0};
    vecs[11] = '{"lw1023",     0, 1'b0, 32'd1023, 32'h0,        3'b010, 1'b0, 32'h12345678};
    vecs[12] = '{"st_f3_100",  0, 1'b1, 32'd7,    32'hFFFFFFFF, 3'b100, 1'b1, 32'h0};
    vecs[13] = '{"sh7",        1, 1'b1, 32'd7,    32'hAAAA1234, 3'b001, 1'b0, 32'h0};
    vecs[14] = '{"lw7_sh",     0, 1'b0, 32'd7,    32'h0,        3'b010, 1'b0, 32'h00001234};
    vecs[15] = '{"sb7",        0, 1'b1, 32'd7,    32'hCCCCCC55, 3'b000, 1'b0, 32'h0};
    vecs[16] = '{"lw7_sb",     1, 1'b0, 32'd7,    32'h0,        3'b010, 1'b0, 32'h00001255};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset mem ctl", {30'd0, mem_MemRead, mem_MemWrite}, 32'd0);
    check("reset mem addr", mem_address, 32'd0);
    check("reset resp", {30'd0, p0_resp_valid, p1_resp_valid}, 32'd0);
    check("reset ready", {30'd0, p0_req_ready, p1_req_ready}, 32'd0);

    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Contention from reset: p0 first, then strict alternation every 3 cycles.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0, 3'b010);
    drive(1, 1'b1, 1'b0, 32'd1023, 32'd0, 3'b010);
    cyc = 0;
    last_cycle = 0;
    for (int k = 0; k < 4; k++) begin
      int exp_p;
      exp_p = k % 2;
      got = 1'b0;
      for (int t = 0; t < 8 && !got; t++) begin
        #1;
        if (p0_req_ready || p1_req_ready) got = 1'b1;
        else begin @(negedge clk); cyc++; end
      end
      if (!got) begin
        checks++; failures++;
        $display("FAIL rr grant %0d: no ready within bound", k);
      end else begin
        check($sformatf("rr grant %0d p0", k), 32'(p0_req_ready), 32'(exp_p == 0));
        check($sformatf("rr grant %0d p1", k), 32'(p1_req_ready), 32'(exp_p == 1));
        if (k > 0) check($sformatf("rr spacing %0d", k), 32'(cyc - last_cycle), 32'd3);
        last_cycle = cyc;
        @(negedge clk); cyc++;
        @(negedge clk); cyc++;
        check($sformatf("rr resp %0d", k), 32'(rv(exp_p)), 32'd1);
        check($sformatf("rr other resp %0d", k), 32'(rv(1 - exp_p)), 32'd0);
        check($sformatf("rr rdata %0d", k), rd(exp_p), (exp_p == 0) ? 32'hDEADBEEF : 32'h12345678);
        @(negedge clk); cyc++;
      end
    end
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    repeat (3) @(negedge clk);

    // Reset during the ACCESS cycle of a store: write is aborted.
    drive(0, 1'b1, 1'b1, 32'd9, 32'hCAFEF00D, 3'b010);
    #1 check("rst-mid ready", 32'(p0_req_ready), 32'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    check("rst-mid write on", 32'(mem_MemWrite), 32'd1);
    #1 reset = 1'b1;
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0, 3'b010);
    drive(1, 1'b1, 1'b0, 32'd5, 32'd0, 3'b010);
    #1;
    check("rst-mid write off", 32'(mem_MemWrite), 32'd0);
    check("rst-mid addr", mem_address, 32'd0);
    check("rst-mid wdata", mem_write_data, 32'd0);
    check("rst-mid ready gated", {30'd0, p0_req_ready, p1_req_ready}, 32'd0);
    @(negedge clk);
    check("rst-mid no resp", {30'd0, p0_resp_valid, p1_resp_valid}, 32'd0);
    check("rst-mid mem unchanged", mem[9], 32'd0);
    reset = 1'b0;
    #1;
    check("post-rst p0 first", {30'd0, p1_req_ready, p0_req_ready}, 32'd1);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("post-rst resp", 32'(p0_resp_valid), 32'd1);
    check("post-rst rdata", p0_resp_rdata, 32'hDEADBEEF);

    // p1 raises then withdraws valid while p0 owns the bus.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd7, 32'd0, 3'b010);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    drive(1, 1'b1, 1'b1, 32'd7, 32'hBADBAD00, 3'b010);
    @(negedge clk);
    check("wd p1 ready in access", 32'(p1_req_ready), 32'd0);
    @(negedge clk);
    check("wd p1 ready in resp", 32'(p1_req_ready), 32'd0);
    check("wd p0 resp", p0_resp_rdata, 32'h00001255);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("wd quiet %0d", i),
            {28'd0, p1_resp_valid, p0_resp_valid, mem_MemRead, mem_MemWrite}, 32'd0);
    end
    check("wd mem intact", mem[7], 32'h00001255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
